// File: rtl/result_collector.sv
// result_collector: drains the result memories of a row of PEs once all of
// them report completion and serialises the words PE-major, address-minor
// onto a single 32-bit stb/ack stream.
//
// Ports:
//   clk, rst                 clock; asynchronous active-low reset
//   pe_done[N_PE]            per-PE completion flags (sampled only in IDLE)
//   pe_c[32*N_PE]            PE read data, valid the cycle after the strobe
//   pe_addr, pe_mem_select   shared read address, one-hot read strobe
//   out_data/pe/addr/last    result word, source PE, source address, last flag
//   out_stb, out_ack         output handshake
//   busy, done               drain in progress; sticky drain complete
module result_collector #(
  parameter int unsigned N_PE     = 4,
  parameter int unsigned LOG_SIZE = 3,
  parameter int unsigned PE_W     = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_PE-1:0]       pe_done,
  input  logic [32*N_PE-1:0]    pe_c,
  output logic [LOG_SIZE-1:0]   pe_addr,
  output logic [N_PE-1:0]       pe_mem_select,
  output logic [31:0]           out_data,
  output logic [PE_W-1:0]       out_pe,
  output logic [LOG_SIZE-1:0]   out_addr,
  output logic                  out_last,
  output logic                  out_stb,
  input  logic                  out_ack,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned DEPTH = 1 << LOG_SIZE;
  localparam logic [LOG_SIZE-1:0] ADDR_MAX = LOG_SIZE'(DEPTH - 1);
  localparam logic [PE_W-1:0]     PE_MAX   = PE_W'(N_PE - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_HOLD,
    ST_DONE
  } state_t;

  state_t state_q, state_d;

  logic [PE_W-1:0]     pe_cnt_q, pe_cnt_d;
  logic [LOG_SIZE-1:0] addr_cnt_q, addr_cnt_d;

  logic [LOG_SIZE-1:0] pe_addr_d;
  logic [N_PE-1:0]     pe_mem_select_d;
  logic [31:0]         out_data_d;
  logic [PE_W-1:0]     out_pe_d;
  logic [LOG_SIZE-1:0] out_addr_d;
  logic                out_last_d;
  logic                out_stb_d;
  logic                busy_d;
  logic                done_d;

  logic [31:0]         word_sel;
  logic                is_last;

  // One-hot strobe for a PE index.
  function automatic logic [N_PE-1:0] onehot(input logic [PE_W-1:0] idx);
    logic [N_PE-1:0] v;
    v = '0;
    for (int unsigned p = 0; p < N_PE; p++) begin
      if (idx == PE_W'(p)) v[p] = 1'b1;
    end
    return v;
  endfunction

  // Read-data mux selecting the slice of the PE currently being read.
  always_comb begin
    word_sel = '0;
    for (int unsigned p = 0; p < N_PE; p++) begin
      if (pe_cnt_q == PE_W'(p)) word_sel = pe_c[32*p +: 32];
    end
  end

  assign is_last = (pe_cnt_q == PE_MAX) && (addr_cnt_q == ADDR_MAX);

  // State, counter and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      pe_cnt_q      <= '0;
      addr_cnt_q    <= '0;
      pe_addr       <= '0;
      pe_mem_select <= '0;
      out_data      <= '0;
      out_pe        <= '0;
      out_addr      <= '0;
      out_last      <= 1'b0;
      out_stb       <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      state_q       <= state_d;
      pe_cnt_q      <= pe_cnt_d;
      addr_cnt_q    <= addr_cnt_d;
      pe_addr       <= pe_addr_d;
      pe_mem_select <= pe_mem_select_d;
      out_data      <= out_data_d;
      out_pe        <= out_pe_d;
      out_addr      <= out_addr_d;
      out_last      <= out_last_d;
      out_stb       <= out_stb_d;
      busy          <= busy_d;
      done          <= done_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (&pe_done) state_d = ST_ISSUE;
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT:  state_d = ST_HOLD;
      ST_HOLD:  if (out_ack) state_d = out_last ? ST_DONE : ST_ISSUE;
      ST_DONE:  state_d = ST_DONE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Next values of counters and registered outputs; the strobe is a
  // single-cycle pulse so it defaults to 0 rather than holding.
  always_comb begin
    pe_cnt_d        = pe_cnt_q;
    addr_cnt_d      = addr_cnt_q;
    pe_addr_d       = pe_addr;
    pe_mem_select_d = '0;
    out_data_d      = out_data;
    out_pe_d        = out_pe;
    out_addr_d      = out_addr;
    out_last_d      = out_last;
    out_stb_d       = out_stb;
    busy_d          = busy;
    done_d          = done;
    case (state_q)
      ST_IDLE: begin
        if (&pe_done) begin
          busy_d          = 1'b1;
          pe_addr_d       = addr_cnt_q;
          pe_mem_select_d = onehot(pe_cnt_q);
        end
      end
      ST_WAIT: begin
        // Read data returned for the strobe issued in the previous cycle.
        out_data_d = word_sel;
        out_pe_d   = pe_cnt_q;
        out_addr_d = addr_cnt_q;
        out_last_d = is_last;
        out_stb_d  = 1'b1;
      end
      ST_HOLD: begin
        if (out_ack) begin
          out_stb_d  = 1'b0;
          out_last_d = 1'b0;
          if (out_last) begin
            done_d = 1'b1;
            busy_d = 1'b0;
          end else begin
            if (addr_cnt_q == ADDR_MAX) begin
              addr_cnt_d = '0;
              pe_cnt_d   = pe_cnt_q + PE_W'(1);
            end else begin
              addr_cnt_d = addr_cnt_q + LOG_SIZE'(1);
            end
            // Issue the next read straight away using the advanced counters.
            pe_addr_d       = addr_cnt_d;
            pe_mem_select_d = onehot(pe_cnt_d);
          end
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_result_collector.sv
module tb_result_collector;

  localparam int unsigned N_PE     = 2;
  localparam int unsigned LOG_SIZE = 2;
  localparam int unsigned PE_W     = 1;

  typedef struct packed {
    logic [0:0]  pe;
    logic [1:0]  addr;
    logic [31:0] data;
    logic        last;
  } word_t;

  logic                clk = 1'b0;
  logic                rst;
  logic [N_PE-1:0]     pe_done;
  logic [32*N_PE-1:0]  pe_c;
  logic [LOG_SIZE-1:0] pe_addr;
  logic [N_PE-1:0]     pe_mem_select;
  logic [31:0]         out_data;
  logic [PE_W-1:0]     out_pe;
  logic [LOG_SIZE-1:0] out_addr;
  logic                out_last;
  logic                out_stb;
  logic                out_ack;
  logic                busy;
  logic                done;

  logic [31:0] mem_q [N_PE];
  word_t       vec [8];
  word_t       xfers [$];
  int          viol;
  logic [N_PE-1:0] prev_sel;
  int          pass_cnt;
  int          total_cnt;

  result_collector #(.N_PE(N_PE), .LOG_SIZE(LOG_SIZE), .PE_W(PE_W)) dut (
    .clk(clk), .rst(rst), .pe_done(pe_done), .pe_c(pe_c),
    .pe_addr(pe_addr), .pe_mem_select(pe_mem_select),
    .out_data(out_data), .out_pe(out_pe), .out_addr(out_addr),
    .out_last(out_last), .out_stb(out_stb), .out_ack(out_ack),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // PE memory models: registered read, garbage when not strobed.
  always @(posedge clk) begin
    for (int p = 0; p < N_PE; p++) begin
      if (pe_mem_select[p]) mem_q[p] <= 32'h3F80_0000 + 32'(16 * p) + 32'(pe_addr);
      else                  mem_q[p] <= 32'hDEAD_BEEF;
    end
  end
  assign pe_c = {mem_q[1], mem_q[0]};

  // Transfer log and strobe-rule monitor.
  initial begin
    viol = 0;
    prev_sel = '0;
  end
  always @(posedge clk) begin
    if (out_stb && out_ack) xfers.push_back({out_pe, out_addr, out_data, out_last});
    if (pe_mem_select != '0 && (prev_sel != '0 || out_stb)) viol = viol + 1;
    if ($countones(pe_mem_select) > 1) viol = viol + 1;
    prev_sel = pe_mem_select;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    out_ack = 1'b0;
    pe_done = '0;
    tick();
    tick();
    rst = 1'b1;
    xfers.delete();
  endtask

  task automatic wait_done(input string name);
    for (int i = 0; i < 200 && !done; i++) tick();
    chk(name, 64'(done), 64'd1);
  endtask

  task automatic check_stream(input string name);
    chk({name, "_len"}, 64'(xfers.size()), 64'd8);
    for (int i = 0; i < 8; i++) begin
      if (i < xfers.size()) chk($sformatf("%s_w%0d", name, i), 64'(xfers[i]), 64'(vec[i]));
    end
  endtask

  initial begin
    logic ok;
    pass_cnt = 0;
    total_cnt = 0;
    for (int p = 0; p < N_PE; p++) mem_q[p] = 32'hDEAD_BEEF;

    vec[0] = '{pe: 1'd0, addr: 2'd0, data: 32'h3F80_0000, last: 1'b0};
    vec[1] = '{pe: 1'd0, addr: 2'd1, data: 32'h3F80_0001, last: 1'b0};
    vec[2] = '{pe: 1'd0, addr: 2'd2, data: 32'h3F80_0002, last: 1'b0};
    vec[3] = '{pe: 1'd0, addr: 2'd3, data: 32'h3F80_0003, last: 1'b0};
    vec[4] = '{pe: 1'd1, addr: 2'd0, data: 32'h3F80_0010, last: 1'b0};
    vec[5] = '{pe: 1'd1, addr: 2'd1, data: 32'h3F80_0011, last: 1'b0};
    vec[6] = '{pe: 1'd1, addr: 2'd2, data: 32'h3F80_0012, last: 1'b0};
    vec[7] = '{pe: 1'd1, addr: 2'd3, data: 32'h3F80_0013, last: 1'b1};

    // Reset state.
    rst = 1'b0;
    out_ack = 1'b0;
    pe_done = '0;
    #1;
    chk("reset_outputs",
        64'({pe_addr, pe_mem_select, out_data, out_pe, out_addr, out_last, out_stb, busy, done}),
        64'd0);
    tick();
    rst = 1'b1;
    tick();

    // Full drain with ack held high, cycle accurate.
    out_ack = 1'b1;
    pe_done = 2'b11;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk($sformatf("issue%0d_sel", k), 64'({pe_mem_select, pe_addr}),
          64'({2'b01 << vec[k].pe, vec[k].addr}));
      if (k == 0) chk("busy_on_start", 64'(busy), 64'd1);
      tick();
      chk($sformatf("wait%0d_sel", k), 64'({pe_mem_select, out_stb}), 64'd0);
      tick();
      chk($sformatf("hold%0d_word", k), 64'({out_stb, out_pe, out_addr, out_data, out_last}),
          64'({1'b1, vec[k]}));
    end
    tick();
    chk("done_at_25", 64'({done, busy, out_stb}), 64'({1'b1, 1'b0, 1'b0}));
    check_stream("drain1");

    // DONE: ack toggling causes no transfers, done stays.
    ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      out_ack = 1'($urandom_range(0, 1));
      tick();
      if (!done || out_stb || busy || pe_mem_select != '0) ok = 1'b0;
    end
    chk("done_sticky", 64'(ok), 64'd1);
    chk("done_no_xfer", 64'(xfers.size()), 64'd8);

    // Only pe_done[0] high: no activity; start 3 cycles after bit 1 rises.
    do_reset();
    pe_done = 2'b01;
    ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      out_ack = 1'($urandom_range(0, 1));
      tick();
      if (pe_mem_select != '0 || busy || out_stb) ok = 1'b0;
    end
    chk("partial_done_idle", 64'(ok), 64'd1);
    chk("idle_no_xfer", 64'(xfers.size()), 64'd0);
    out_ack = 1'b1;
    pe_done = 2'b11;
    tick();
    tick();
    chk("start_stb_t2", 64'(out_stb), 64'd0);
    tick();
    chk("start_stb_t3", 64'({out_stb, out_data}), 64'({1'b1, 32'h3F80_0000}));
    wait_done("drain2_done");
    check_stream("drain2");

    // Back-pressure on word (0,2), then pe_done dropped mid-drain.
    do_reset();
    out_ack = 1'b1;
    pe_done = 2'b11;
    for (int i = 0; i < 7; i++) tick();
    out_ack = 1'b0;
    tick();
    tick();
    chk("bp_hold_word", 64'({out_stb, out_pe, out_addr, out_data}),
        64'({1'b1, 1'b0, 2'd2, 32'h3F80_0002}));
    ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (!out_stb || out_data != 32'h3F80_0002 || out_addr != 2'd2 || pe_mem_select != '0)
        ok = 1'b0;
    end
    chk("bp_stable", 64'(ok), 64'd1);
    out_ack = 1'b1;
    pe_done = 2'b00;
    tick();
    chk("bp_next_issue", 64'({out_stb, pe_mem_select, pe_addr}), 64'({1'b0, 2'b01, 2'd3}));
    wait_done("drain3_done");
    check_stream("drain3");

    // Reset during HOLD of word (1,1), restart from (0,0).
    do_reset();
    out_ack = 1'b1;
    pe_done = 2'b11;
    for (int i = 0; i < 18; i++) tick();
    chk("pre_reset_word", 64'({out_stb, out_pe, out_addr}), 64'({1'b1, 1'b1, 2'd1}));
    rst = 1'b0;
    #1;
    chk("mid_reset_outputs",
        64'({pe_addr, pe_mem_select, out_data, out_pe, out_addr, out_last, out_stb, busy, done}),
        64'd0);
    tick();
    rst = 1'b1;
    xfers.delete();
    tick();
    chk("restart_issue", 64'({pe_mem_select, pe_addr, busy}), 64'({2'b01, 2'd0, 1'b1}));
    tick();
    tick();
    chk("restart_word0", 64'({out_stb, out_pe, out_addr, out_data}),
        64'({1'b1, 1'b0, 2'd0, 32'h3F80_0000}));
    wait_done("drain4_done");
    check_stream("drain4");

    chk("strobe_rules", 64'(viol), 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/result_collector.md
# result_collector

Drains the result memories of a row of processing elements (PEs) after a matrix multiply finishes and serialises them onto a single 32-bit stb/ack output stream. It sits directly downstream of the PE chain and consumes each PE's `c` read port through the PE's external `addr`/`mem_select` access path. It starts automatically once every PE reports completion, then emits words PE-major, address-minor. It never writes PE memory.

## Interface
- `N_PE`, 4, number of PEs drained (≥1).
- `LOG_SIZE`, 3, PE memory address width; each PE is drained over DEPTH = 2**LOG_SIZE addresses.
- `PE_W`, 2, width of `out_pe` (≥ clog2(N_PE), min 1).
- `clk`  in  1  sole clock; all state changes on its rising edge.
- `rst`  in  1  asynchronous, active-low reset: low forces reset state immediately; released synchronously by the system.
- `pe_done`  in  N_PE  per-PE `output_stb`; bit p high = PE p finished.
- `pe_c`  in  32*N_PE  PE p read data on bits [32p+31:32p]; valid the cycle after its read strobe.
- `pe_addr`  out  LOG_SIZE  shared read address to all PEs.
- `pe_mem_select`  out  N_PE  one-hot read strobe; at most one bit high.
- `out_data`  out  32  result word.
- `out_pe`  out  PE_W  source PE index of `out_data`.
- `out_addr`  out  LOG_SIZE  source address of `out_data`.
- `out_last`  out  1  high with the final word (PE N_PE-1, address DEPTH-1).
- `out_stb`  out  1  `out_data`/`out_pe`/`out_addr`/`out_last` valid.
- `out_ack`  in  1  consumer accepts; transfer occurs on a cycle where `out_stb` and `out_ack` are both high.
- `busy`  out  1  drain in progress.
- `done`  out  1  sticky; all words transferred.

## Operation
- All outputs are registered. Reset values: every output 0, both counters 0, state IDLE.
- pe_cnt (PE_W bits) and addr_cnt (LOG_SIZE bits) select the current word.
- IDLE: `busy`=0. When &`pe_done`=1, go to ISSUE with `busy`=1. `pe_done` is sampled only in IDLE; later deassertion is ignored.
- ISSUE (1 cycle): `pe_addr`=addr_cnt, `pe_mem_select`=one-hot(pe_cnt). Go to WAIT.
- WAIT (1 cycle): `pe_mem_select`=0. At the cycle's end, capture `pe_c` slice pe_cnt into `out_data` and load `out_pe`=pe_cnt and `out_addr`=addr_cnt. Set `out_last` when pe_cnt=N_PE-1 and addr_cnt=DEPTH-1. Set `out_stb`=1 and go to HOLD.
- HOLD: hold all out_* stable while `out_ack`=0. On `out_ack`=1:
  - Clear `out_stb` and `out_last`.
  - If the word was last: go to DONE.
  - Otherwise: if addr_cnt=DEPTH-1, set addr_cnt=0 and increment pe_cnt; else increment addr_cnt. Go to ISSUE.
- DONE: `done`=1, `busy`=0, `out_stb`=0. Remain in DONE until reset.
- `out_ack` is ignored outside HOLD.
- Reset asserted mid-drain:
  - Immediate return to reset values, including `pe_mem_select`=0.
  - After release, a fresh drain starts from PE 0, address 0 if &`pe_done` is still high.

## Timing
- Start latency: &`pe_done` rises in cycle T → ISSUE in T+1 → WAIT in T+2 → `out_stb` high in T+3.
- Read latency: data is on `pe_c` exactly one cycle after the `pe_mem_select` pulse and is captured at the end of WAIT.
- Throughput: 3 cycles per word when `out_ack` is held high. A drain takes 3·N_PE·DEPTH cycles plus the 1-cycle IDLE exit.
- `pe_mem_select` pulses for exactly one cycle per word, never two consecutive cycles, and never while `out_stb`=1.
- `out_stb` stays high with stable data until the ack cycle and drops in the following cycle.
- `done` rises the cycle after the last transfer.

## Test plan
- N_PE=2, LOG_SIZE=2. PE p memory models return 0x3F800000 + 16p + a. Raise both `pe_done` with `out_ack` tied high → 8 words in order (0,0)…(1,3) with matching data, `out_last` only on (1,3), `done`=1 at cycle 25 after start.
- Raise only `pe_done`[0] for 10 cycles, then raise bit 1 → no `pe_mem_select` activity before bit 1 rises; first `out_stb` appears 3 cycles after it rises.
- Back-pressure: hold `out_ack` low for 5 cycles on word (0,2) → `out_stb` and the data 0x3F800002 stay stable and no `pe_mem_select` pulses occur; the next ISSUE comes the cycle after ack.
- Drop `pe_done` to 0 mid-drain → drain completes normally with all 8 words.
- Assert `rst` low during HOLD of word (1,1) → all outputs read 0 immediately. Release with `pe_done` still high → drain restarts at (0,0).
- Toggle `out_ack` randomly while in IDLE and DONE → no transfers, and `done` stays 1 in DONE.
